filter_capture_buffer: RTL



---
 rtl/filter_capture_buffer.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/filter_capture_buffer.sv
// Captures a window of DEPTH filter output samples after SKIP discarded ones, then replays them over valid/ready.
// Optional feature macro: CAPTURE_STATS_EN adds per-window signed stat_min / stat_max outputs.
module filter_capture_buffer #(
    parameter int DEPTH = 1000,
    parameter int DW    = 16,
    parameter int SKIP  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] din,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 rd_ready,
    output logic                 rd_valid,
    output logic signed [DW-1:0] rd_data,
    output logic                 rd_last,
    output logic                 busy,
    output logic                 done
`ifdef CAPTURE_STATS_EN
    ,
    output logic signed [DW-1:0] stat_min,
    output logic signed [DW-1:0] stat_max
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = ($clog2(SKIP + 1) > 0) ? $clog2(SKIP + 1) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [SW-1:0] SKIP_LAST = SW'((SKIP > 0) ? (SKIP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SKIP    = 2'd1,
        S_CAPTURE = 2'd2,
        S_READOUT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    skip_cnt_q, skip_cnt_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic             issue_done_q, issue_done_d;
    logic             ram_vld_q, ram_vld_d;
    logic             ram_last_q, ram_last_d;
    logic             rd_valid_q, rd_valid_d;
    logic [DW-1:0]    rd_data_q, rd_data_d;
    logic             rd_last_q, rd_last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wr_en_s, rd_en_s;
    logic             out_adv_s, mid_adv_s;
    logic [DW-1:0]    ram_q;
    logic [DW-1:0]    mem [DEPTH];

    // Readout is a two-stage pipe (RAM data register, then output register) that stalls as a whole.
    assign out_adv_s = !rd_valid_q || rd_ready;
    assign mid_adv_s = !ram_vld_q || out_adv_s;

    // Next-state and next-output computation for the capture/readout sequencer.
    always_comb begin
        state_d      = state_q;
        skip_cnt_d   = skip_cnt_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        issue_done_d = issue_done_q;
        ram_vld_d    = ram_vld_q;
        ram_last_d   = ram_last_q;
        rd_valid_d   = rd_valid_q;
        rd_data_d    = rd_data_q;
        rd_last_d    = rd_last_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        wr_en_s      = 1'b0;
        rd_en_s      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    busy_d     = 1'b1;
                    skip_cnt_d = '0;
                    wr_addr_d  = '0;
                    state_d    = (SKIP == 0) ? S_CAPTURE : S_SKIP;
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_SKIP: begin
                if (skip_cnt_q == SKIP_LAST) begin
                    skip_cnt_d = '0;
                    state_d    = S_CAPTURE;
                end else begin
                    skip_cnt_d = skip_cnt_q + SW'(1);
                end
            end
            S_CAPTURE: begin
                wr_en_s = 1'b1;
                if (wr_addr_q == LAST_ADDR) begin
                    wr_addr_d    = '0;
                    rd_addr_d    = '0;
                    issue_done_d = 1'b0;
                    ram_vld_d    = 1'b0;
                    state_d      = S_READOUT;
                end else begin
                    wr_addr_d = wr_addr_q + AW'(1);
                end
            end
            S_READOUT: begin
                if (out_adv_s) begin
                    rd_valid_d = ram_vld_q;
                    rd_last_d  = ram_vld_q && ram_last_q;
                    rd_data_d  = ram_vld_q ? ram_q : rd_data_q;
                end else begin
                    rd_valid_d = rd_valid_q;
                end
                if (mid_adv_s) begin
                    ram_vld_d  = !issue_done_q;
                    ram_last_d = (rd_addr_q == LAST_ADDR);
                    rd_en_s    = !issue_done_q;
                    if (issue_done_q) begin
                        rd_addr_d = rd_addr_q;
                    end else if (rd_addr_q == LAST_ADDR) begin
                        issue_done_d = 1'b1;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                    end
                end else begin
                    ram_vld_d = ram_vld_q;
                end
                if (rd_valid_q && rd_ready && rd_last_q) begin
                    state_d    = S_IDLE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    ram_vld_d  = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort wins over arm and over any handshake in flight.
        if (abort) begin
            state_d      = S_IDLE;
            busy_d       = 1'b0;
            done_d       = 1'b0;
            rd_valid_d   = 1'b0;
            rd_last_d    = 1'b0;
            ram_vld_d    = 1'b0;
            skip_cnt_d   = '0;
            wr_addr_d    = '0;
            rd_addr_d    = '0;
            issue_done_d = 1'b0;
            wr_en_s      = 1'b0;
            rd_en_s      = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            skip_cnt_q   <= '0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            issue_done_q <= 1'b0;
            ram_vld_q    <= 1'b0;
            ram_last_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_last_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            skip_cnt_q   <= skip_cnt_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            issue_done_q <= issue_done_d;
            ram_vld_q    <= ram_vld_d;
            ram_last_q   <= ram_last_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            rd_last_q    <= rd_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Sample RAM: synchronous write port and registered read port without reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_addr_q] <= din;
        end
        if (rd_en_s) begin
            ram_q <= mem[rd_addr_q];
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_last  = rd_last_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef CAPTURE_STATS_EN
    logic signed [DW-1:0] stat_min_q, stat_min_d;
    logic signed [DW-1:0] stat_max_q, stat_max_d;

    // Running extremes; the first stored sample of a window re-seeds both.
    always_comb begin
        stat_min_d = stat_min_q;
        stat_max_d = stat_max_q;
        if (wr_en_s) begin
            if (wr_addr_q == '0) begin
                stat_min_d = din;
                stat_max_d = din;
            end else begin
                stat_min_d = (din < stat_min_q) ? din : stat_min_q;
                stat_max_d = (din > stat_max_q) ? din : stat_max_q;
            end
        end else begin
            stat_min_d = stat_min_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_min_q <= '0;
            stat_max_q <= '0;
        end else begin
            stat_min_q <= stat_min_d;
            stat_max_q <= stat_max_d;
        end
    end

    assign stat_min = stat_min_q;
    assign stat_max = stat_max_q;
`endif

endmodule
